// File: rtl/apu_shared_unit_arbiter.sv
// apu_shared_unit_arbiter: round-robin front-end that lets NB_CORES cores share
// one APU execution unit, tracks the owner of each in-flight op and routes the
// result back to that owner.
//
// Handshake: a core raises req_i[c] and holds it (with its operands, opcode
// and flags stable) until it sees gnt_o[c]=1 in the same cycle; that cycle
// consumes the request and issues it to the unit. Exactly LATENCY cycles later
// rvalid_o[c] pulses for one cycle while result_o/rflags_o carry the result.
// There is no back-pressure on results: the core must accept them.
module apu_shared_unit_arbiter #(
  parameter int NB_CORES   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NARGS      = 3,
  parameter int WOP        = 1,
  parameter int NDSFLAGS   = 3,
  parameter int NUSFLAGS   = 5,
  parameter int LATENCY    = 1,
  parameter int PIPELINED  = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_CORES-1:0]                   req_i,
  output logic [NB_CORES-1:0]                   gnt_o,
  input  logic [NB_CORES*NARGS*DATA_WIDTH-1:0]  operands_i,
  input  logic [NB_CORES*WOP-1:0]               op_i,
  input  logic [NB_CORES*NDSFLAGS-1:0]          flags_i,
  output logic [NB_CORES-1:0]                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                 result_o,
  output logic [NUSFLAGS-1:0]                   rflags_o,
  output logic                                  unit_en_o,
  output logic [NARGS*DATA_WIDTH-1:0]           unit_operands_o,
  output logic [WOP-1:0]                        unit_op_o,
  output logic [NDSFLAGS-1:0]                   unit_flags_o,
  input  logic [DATA_WIDTH-1:0]                 unit_result_i,
  input  logic [NUSFLAGS-1:0]                   unit_flags_i,
  output logic                                  busy_o,
  output logic                                  dbg_state_o  // 1 = iterative FSM in BUSY
);

  localparam int RRW = $clog2(NB_CORES);
  localparam int OPW = NARGS * DATA_WIDTH;

  logic [RRW-1:0]      rr_q, rr_d;
  logic [RRW-1:0]      winner, idx;
  logic                found;
  logic                iter_idle;
  logic                grant_en;
  logic [NB_CORES-1:0] rvalid_raw;
  logic                busy_int;

  // Round-robin search: first requesting core starting at rr_q, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = RRW'((int'(rr_q) + i) % NB_CORES);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grants are suppressed in reset and while an iterative unit is occupied.
  assign grant_en = !rst_i && iter_idle;

  // One-hot grant to the search winner.
  always_comb begin
    gnt_o = '0;
    if (grant_en && found) gnt_o[winner] = 1'b1;
  end

  assign unit_en_o = |gnt_o;

  // Pointer moves just past the core that was served; holds otherwise.
  always_comb begin
    rr_d = rr_q;
    if (unit_en_o) rr_d = (winner == RRW'(NB_CORES - 1)) ? '0 : winner + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  // Issue mux: the winner's slices go to the unit; zeros when nothing issues.
  always_comb begin
    unit_operands_o = '0;
    unit_op_o       = '0;
    unit_flags_o    = '0;
    if (unit_en_o) begin
      unit_operands_o = operands_i[int'(winner)*OPW +: OPW];
      unit_op_o       = op_i[int'(winner)*WOP +: WOP];
      unit_flags_o    = flags_i[int'(winner)*NDSFLAGS +: NDSFLAGS];
    end
  end

  assign result_o = unit_result_i;
  assign rflags_o = unit_flags_i;
  assign rvalid_o = rst_i ? '0 : rvalid_raw;
  assign busy_o   = busy_int;

  if (LATENCY == 0) begin : g_lat0
    // Combinational unit: the result belongs to whoever is granted now.
    assign rvalid_raw  = gnt_o;
    assign busy_int    = 1'b0;
    assign iter_idle   = 1'b1;
    assign dbg_state_o = 1'b0;
  end else if (PIPELINED != 0) begin : g_pipe
    logic [LATENCY-1:0] tag_v_q;
    logic [RRW-1:0]     tag_own_q [LATENCY];

    // Owner tags travel alongside the unit's pipe registers.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tag_v_q <= '0;
        for (int s = 0; s < LATENCY; s++) tag_own_q[s] <= '0;
      end else begin
        tag_v_q[0]   <= unit_en_o;
        tag_own_q[0] <= winner;
        for (int s = 1; s < LATENCY; s++) begin
          tag_v_q[s]   <= tag_v_q[s-1];
          tag_own_q[s] <= tag_own_q[s-1];
        end
      end
    end

    // Last stage valid means the unit output belongs to that owner this cycle.
    always_comb begin
      rvalid_raw = '0;
      if (tag_v_q[LATENCY-1]) rvalid_raw[tag_own_q[LATENCY-1]] = 1'b1;
    end

    assign busy_int    = |tag_v_q;
    assign iter_idle   = 1'b1;
    assign dbg_state_o = 1'b0;
  end else begin : g_iter
    typedef enum logic {S_IDLE, S_BUSY} state_e;
    state_e         state_q, state_d;
    logic [RRW-1:0] own_q, own_d;
    logic [3:0]     cnt_q, cnt_d;

    // FSM state, owner and countdown registers.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        own_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        own_q   <= own_d;
        cnt_q   <= cnt_d;
      end
    end

    // Single op in flight: count down LATENCY cycles, then hand back result.
    always_comb begin
      state_d    = state_q;
      own_d      = own_q;
      cnt_d      = cnt_q;
      rvalid_raw = '0;
      case (state_q)
        S_IDLE: begin
          if (unit_en_o) begin
            state_d = S_BUSY;
            own_d   = winner;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            rvalid_raw[own_q] = 1'b1;
            state_d           = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign iter_idle   = (state_q == S_IDLE);
    assign busy_int    = (state_q == S_BUSY);
    assign dbg_state_o = busy_int;
  end

endmodule

// File: tb/tb_apu_shared_unit_arbiter.sv
// Bench for apu_shared_unit_arbiter: several parameter sets side by side, each
// with its own driver, behavioural unit, reference model and result monitor.
module tb_apu_shared_unit_arbiter;

  localparam int NC      = 4;
  localparam int DW      = 32;
  localparam int NA      = 3;
  localparam int OPW     = NA * DW;
  localparam int NCFG    = 5;
  localparam int N_BURST = 80;
  localparam int N_RAND  = 160;
  localparam int N_DRAIN = 40;
  localparam int MID_RST = N_BURST + 60;

  typedef struct packed {
    int          due;
    logic [1:0]  core;
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int n_done = 0;

  // Configurations: {LATENCY, PIPELINED}
  function automatic int cfg_lat(input int g);
    case (g)
      0: return 2;
      1: return 5;
      2: return 0;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_pipe(input int g);
    case (g)
      1: return 0;
      4: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic logic [NC-1:0] pat_of(input int i);
    case (i)
      0: return 4'b1111;
      1: return 4'b1010;
      default: return 4'b0011;
    endcase
  endfunction

  // What the stand-in execution unit computes from an issued op.
  function automatic logic [DW-1:0] unit_res(input logic [OPW-1:0] a, input logic o,
                                             input logic [2:0] f);
    return (a[31:0] + a[63:32]) ^ {a[79:64], a[95:80]} ^ {28'd0, o, f};
  endfunction

  function automatic logic [4:0] unit_fl(input logic [OPW-1:0] a, input logic o,
                                         input logic [2:0] f);
    return a[4:0] ^ a[68:64] ^ {1'b0, f, o};
  endfunction

  task automatic chk(input int g, input string nm, input logic [127:0] act,
                     input logic [127:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL cfg%0d %s: got %0h expected %0h (t=%0t)", g, nm, act, exp_v, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int LAT = cfg_lat(g);
    localparam int PIP = cfg_pipe(g);
    localparam int LI  = (LAT == 0) ? 0 : LAT - 1;
    localparam int GAP = (PIP == 0 && LAT > 0) ? LAT + 1 : 1;

    logic              rst;
    logic [NC-1:0]     req, gnt, rvalid;
    logic [NC*OPW-1:0] operands;
    logic [NC-1:0]     op;
    logic [NC*3-1:0]   flags;
    logic [DW-1:0]     result, u_result;
    logic [4:0]        rflags, u_flags;
    logic              u_en, u_op, busy, dbg;
    logic [OPW-1:0]    u_ops;
    logic [2:0]        u_fl;

    logic [OPW-1:0]    c_ops [NC];
    logic              c_op  [NC];
    logic [2:0]        c_fl  [NC];

    int            cyc = 0;
    exp_t          exp_q[$];
    int            m_rr = 0;
    int            free_at = 0;
    int            pidx = 0;
    logic [NC-1:0] m_gnt = '0;

    logic [DW-1:0] pr [9];
    logic [4:0]    pf [9];

    for (genvar c = 0; c < NC; c++) begin : pk
      assign operands[c*OPW +: OPW] = c_ops[c];
      assign op[c]                  = c_op[c];
      assign flags[c*3 +: 3]        = c_fl[c];
    end

    apu_shared_unit_arbiter #(
      .NB_CORES(NC), .DATA_WIDTH(DW), .NARGS(NA), .WOP(1), .NDSFLAGS(3),
      .NUSFLAGS(5), .LATENCY(LAT), .PIPELINED(PIP)
    ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
      .operands_i(operands), .op_i(op), .flags_i(flags),
      .rvalid_o(rvalid), .result_o(result), .rflags_o(rflags),
      .unit_en_o(u_en), .unit_operands_o(u_ops), .unit_op_o(u_op),
      .unit_flags_o(u_fl), .unit_result_i(u_result), .unit_flags_i(u_flags),
      .busy_o(busy), .dbg_state_o(dbg)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in unit: LAT pipe registers (combinational when LAT == 0).
    always @(posedge clk) begin
      pr[0] <= unit_res(u_ops, u_op, u_fl);
      pf[0] <= unit_fl(u_ops, u_op, u_fl);
      for (int s = 1; s < 9; s++) begin
        pr[s] <= pr[s-1];
        pf[s] <= pf[s-1];
      end
    end
    assign u_result = (LAT == 0) ? unit_res(u_ops, u_op, u_fl) : pr[LI];
    assign u_flags  = (LAT == 0) ? unit_fl(u_ops, u_op, u_fl)  : pf[LI];

    task automatic new_ops(input int c);
      c_ops[c] = {$urandom, $urandom, $urandom};
      c_op[c]  = 1'($urandom_range(0, 1));
      c_fl[c]  = 3'($urandom_range(0, 7));
    endtask

    // Reference model step for the current cycle: expected grant, busy, result.
    task automatic check_cycle();
      logic [NC-1:0] eg;
      bit            found;
      bit            eb;
      int            w;
      eg    = '0;
      found = 1'b0;
      eb    = 1'b0;
      w     = 0;
      if (rst) begin
        chk(g, "gnt_in_reset", gnt, 0);
        chk(g, "unit_en_in_reset", u_en, 0);
        exp_q.delete();
        m_rr    = 0;
        free_at = cyc + 1;
        m_gnt   = '0;
      end else begin
        foreach (exp_q[i]) if (exp_q[i].due >= cyc) eb = 1'b1;
        chk(g, "busy", busy, eb);
        chk(g, "dbg_state", dbg, (PIP == 0 && LAT > 0) ? eb : 1'b0);
        for (int i = 0; i < NC; i++) begin
          int c;
          c = (m_rr + i) % NC;
          if (!found && req[c]) begin
            found = 1'b1;
            w     = c;
          end
        end
        if (found && cyc >= free_at) eg[w] = 1'b1;
        chk(g, "gnt", gnt, eg);
        chk(g, "unit_en", u_en, |eg);
        if (eg != '0) begin
          exp_q.push_back('{due: cyc + LAT, core: 2'(w),
                            res: unit_res(c_ops[w], c_op[w], c_fl[w]),
                            fl: unit_fl(c_ops[w], c_op[w], c_fl[w])});
          m_rr    = (w + 1) % NC;
          free_at = cyc + GAP;
        end else begin
          chk(g, "idle_unit_inputs", {u_ops, u_op, u_fl}, 0);
        end
        m_gnt = eg;
      end
    endtask

    // mode 0: burst table, 1: random, 2: drain (no new requests).
    task automatic update_req(input int mode);
      logic [NC-1:0] nr;
      nr = req & ~m_gnt;
      if (mode == 1) begin
        for (int c = 0; c < NC; c++) begin
          if (!nr[c] && $urandom_range(0, 3) != 0) begin
            nr[c] = 1'b1;
            new_ops(c);
          end
        end
      end else if (mode == 0 && nr == '0 && pidx < 3) begin
        nr = pat_of(pidx);
        pidx++;
        for (int c = 0; c < NC; c++) if (nr[c]) new_ops(c);
      end
      req = nr;
    endtask

    // Driver: reset with all requests up, bursts, random traffic, mid-run reset, drain.
    initial begin
      rst = 1'b1;
      req = '1;
      for (int c = 0; c < NC; c++) new_ops(c);
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
      end
      rst = 1'b0;
      for (int n = 0; n < N_BURST + N_RAND + N_DRAIN; n++) begin
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        rst = (n == MID_RST);
        update_req(n < N_BURST ? 0 : (n < N_BURST + N_RAND ? 1 : 2));
      end
      @(negedge clk);
      #2;
      chk(g, "drain_empty", exp_q.size(), 0);
      n_done++;
    end

    // Monitor: every result pulse must match the oldest outstanding op.
    initial begin : mon
      exp_t          e;
      logic [NC-1:0] oh;
      forever begin
        @(negedge clk);
        #1;
        if (rst) begin
          chk(g, "rvalid_in_reset", rvalid, 0);
        end else if (rvalid != '0) begin
          if (exp_q.size() == 0) begin
            chk(g, "spurious_rvalid", rvalid, 0);
          end else begin
            e        = exp_q.pop_front();
            oh       = '0;
            oh[e.core] = 1'b1;
            chk(g, "rvalid_owner", rvalid, oh);
            chk(g, "rvalid_cycle", cyc, e.due);
            chk(g, "result", result, e.res);
            chk(g, "rflags", rflags, e.fl);
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          oh = '0;
          oh[exp_q[0].core] = 1'b1;
          chk(g, "missing_rvalid", rvalid, oh);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Final report once every configuration has finished (bounded wait).
  initial begin
    for (int i = 0; i < 20000 && n_done < NCFG; i++) @(posedge clk);
    if (n_done < NCFG) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d of %0d configs finished", n_done, NCFG);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
